// File: rtl/priv_mode_guard.sv
// Privilege-mode guard: clamps requested modes, grants MACHINE mode only for a
// password-authenticated, time-limited debug session, and locks out brute force.
module priv_mode_guard #(
  parameter int MODE_W         = 2,
  parameter int MAX_USR_MODE   = 1,
  parameter int PWD_W          = 32,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int DEBUG_TIMEOUT  = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [MODE_W-1:0]                  usr_mode,
  input  logic                               debug_req,
  input  logic                               pwd_valid,
  input  logic [PWD_W-1:0]                   pwd_data,
  input  logic [PWD_W-1:0]                   pwd_ref,
  output logic                               pwd_ready,
  output logic [MODE_W-1:0]                  mode_o,
  output logic                               debug_active,
  output logic                               locked,
  output logic [$clog2(MAX_FAILS+1)-1:0]     fail_cnt
);

  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int SESS_W = $clog2(DEBUG_TIMEOUT + 1);
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [MODE_W-1:0] MODE_MACHINE = '1;
  localparam logic [MODE_W-1:0] USR_CAP      = MODE_W'(MAX_USR_MODE);
  localparam logic [FAIL_W-1:0] FAIL_MAX     = FAIL_W'(MAX_FAILS);
  localparam logic [SESS_W-1:0] SESS_LAST    = SESS_W'(DEBUG_TIMEOUT - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST    = LOCK_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_DEBUG,
    S_LOCKOUT
  } state_t;

  state_t              state_q, state_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [MODE_W-1:0]   mode_clamped;
  logic [PWD_W-1:0]    pwd_q, pwd_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic [SESS_W-1:0]   sess_q, sess_d;
  logic [LOCK_W-1:0]   lock_q, lock_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      pwd_q   <= '0;
      fail_q  <= '0;
      sess_q  <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pwd_q   <= pwd_d;
      fail_q  <= fail_d;
      sess_q  <= sess_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    mode_clamped = (usr_mode > USR_CAP) ? USR_CAP : usr_mode;

    // Outside DEBUG the mode tracks the clamped request; counters idle at zero.
    state_d = state_q;
    mode_d  = mode_clamped;
    pwd_d   = pwd_q;
    fail_d  = fail_q;
    sess_d  = '0;
    lock_d  = '0;

    case (state_q)
      S_IDLE: begin
        if (pwd_valid && debug_req) begin
          pwd_d   = pwd_data;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (pwd_q == pwd_ref) begin
          state_d = S_DEBUG;
          mode_d  = MODE_MACHINE;
          fail_d  = '0;
        end else begin
          fail_d  = (fail_q == FAIL_MAX) ? fail_q : fail_q + FAIL_W'(1);
          state_d = (fail_d == FAIL_MAX) ? S_LOCKOUT : S_IDLE;
        end
      end

      S_DEBUG: begin
        // Leaving returns to IDLE, so a timed-out session needs a fresh password.
        if (!debug_req || (sess_q == SESS_LAST)) begin
          state_d = S_IDLE;
        end else begin
          mode_d = MODE_MACHINE;
          sess_d = sess_q + SESS_W'(1);
        end
      end

      S_LOCKOUT: begin
        if (lock_q == LOCK_LAST) begin
          state_d = S_IDLE;
          fail_d  = '0;
        end else begin
          lock_d = lock_q + LOCK_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pwd_ready    = (state_q == S_IDLE);
  assign debug_active = (state_q == S_DEBUG);
  assign locked       = (state_q == S_LOCKOUT);
  assign mode_o       = mode_q;
  assign fail_cnt     = fail_q;

endmodule

// File: tb/tb_priv_mode_guard.sv
// Directed bench for priv_mode_guard: clamping, authentication, lockout,
// debug timeout and reset behaviour with hand-computed expectations.
module tb_priv_mode_guard;

  localparam logic [31:0] REF_PWD = 32'hCAFE_F00D;
  localparam logic [31:0] BAD_PWD = 32'h1234_5678;

  logic        clk;
  logic        rst;
  logic [1:0]  usr_mode;
  logic        debug_req;
  logic        pwd_valid;
  logic [31:0] pwd_data;
  logic [31:0] pwd_ref;
  logic        pwd_ready;
  logic [1:0]  mode_o;
  logic        debug_active;
  logic        locked;
  logic [1:0]  fail_cnt;

  int total;
  int bad;

  priv_mode_guard dut (
    .clk          (clk),
    .rst          (rst),
    .usr_mode     (usr_mode),
    .debug_req    (debug_req),
    .pwd_valid    (pwd_valid),
    .pwd_data     (pwd_data),
    .pwd_ref      (pwd_ref),
    .pwd_ready    (pwd_ready),
    .mode_o       (mode_o),
    .debug_active (debug_active),
    .locked       (locked),
    .fail_cnt     (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one password for a single edge, then wait for the CHECK edge.
  task automatic present(input logic [31:0] pw);
    pwd_valid = 1'b1;
    pwd_data  = pw;
    tick();
    pwd_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; usr_mode = 2'd3; debug_req = 1'b0; pwd_valid = 1'b0;
    pwd_data = '0; pwd_ref = REF_PWD;
    tick(); tick();
    total++;
    if (mode_o !== 2'd0 || debug_active !== 1'b0 || locked !== 1'b0 ||
        fail_cnt !== 2'd0 || pwd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset: mode=%0d dbg=%0b lck=%0b fc=%0d rdy=%0b, want 0 0 0 0 1",
               mode_o, debug_active, locked, fail_cnt, pwd_ready);
    end
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_clamp();
    logic [1:0] req [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
    logic [1:0] exp [4] = '{2'd1, 2'd0, 2'd1, 2'd1};
    debug_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      usr_mode = req[i];
      tick();
      total++;
      if (mode_o !== exp[i] || debug_active !== 1'b0) begin
        bad++;
        $display("FAIL clamp[%0d]: mode=%0d dbg=%0b, want mode=%0d dbg=0",
                 i, mode_o, debug_active, exp[i]);
      end
      $display("clamp usr_mode=%0d -> mode_o=%0d", req[i], mode_o);
    end
  endtask

  task automatic test_ignore_no_debug();
    debug_req = 1'b0; usr_mode = 2'd1;
    pwd_valid = 1'b1; pwd_data = REF_PWD;
    tick(); tick();
    pwd_data = BAD_PWD;
    tick(); tick();
    pwd_valid = 1'b0;
    total++;
    if (pwd_ready !== 1'b1 || debug_active !== 1'b0 || fail_cnt !== 2'd0 || mode_o !== 2'd1) begin
      bad++;
      $display("FAIL ignore_nodbg: rdy=%0b dbg=%0b fc=%0d mode=%0d, want 1 0 0 1",
               pwd_ready, debug_active, fail_cnt, mode_o);
    end
    $display("pwd_valid with debug_req=0 ignored");
  endtask

  task automatic test_debug_entry();
    debug_req = 1'b1; usr_mode = 2'd2;
    pwd_valid = 1'b1; pwd_data = REF_PWD;
    tick();
    pwd_valid = 1'b0;
    total++;
    if (pwd_ready !== 1'b0 || debug_active !== 1'b0 || mode_o !== 2'd1) begin
      bad++;
      $display("FAIL entry_check: rdy=%0b dbg=%0b mode=%0d, want 0 0 1",
               pwd_ready, debug_active, mode_o);
    end
    tick();
    total++;
    if (mode_o !== 2'd3 || debug_active !== 1'b1) begin
      bad++;
      $display("FAIL entry_e1: mode=%0d dbg=%0b, want 3 1", mode_o, debug_active);
    end
    tick();
    total++;
    if (mode_o !== 2'd3 || debug_active !== 1'b1 || pwd_ready !== 1'b0) begin
      bad++;
      $display("FAIL entry_e2: mode=%0d dbg=%0b rdy=%0b, want 3 1 0",
               mode_o, debug_active, pwd_ready);
    end
    debug_req = 1'b0;
    tick();
    total++;
    if (mode_o !== 2'd1 || debug_active !== 1'b0 || pwd_ready !== 1'b1) begin
      bad++;
      $display("FAIL entry_exit: mode=%0d dbg=%0b rdy=%0b, want 1 0 1",
               mode_o, debug_active, pwd_ready);
    end
    $display("debug session entered and left on debug_req drop");
  endtask

  task automatic test_lockout();
    debug_req = 1'b1; usr_mode = 2'd3;
    for (int i = 1; i <= 3; i++) begin
      present(BAD_PWD);
      total++;
      if (fail_cnt !== 2'(i) || locked !== (i == 3) || pwd_ready !== (i != 3)) begin
        bad++;
        $display("FAIL wrong_pwd[%0d]: fc=%0d lck=%0b rdy=%0b, want %0d %0b %0b",
                 i, fail_cnt, locked, pwd_ready, i, (i == 3), (i != 3));
      end
      $display("wrong password %0d -> fail_cnt=%0d locked=%0b", i, fail_cnt, locked);
    end
    total++;
    if (mode_o !== 2'd1) begin
      bad++;
      $display("FAIL lock_mode: mode=%0d, want 1", mode_o);
    end
    // Correct password offered throughout the lockout must be ignored.
    pwd_valid = 1'b1; pwd_data = REF_PWD;
    for (int k = 1; k <= 15; k++) begin
      tick();
      total++;
      if (locked !== 1'b1 || pwd_ready !== 1'b0 || debug_active !== 1'b0) begin
        bad++;
        $display("FAIL lock_hold[%0d]: lck=%0b rdy=%0b dbg=%0b, want 1 0 0",
                 k, locked, pwd_ready, debug_active);
      end
    end
    pwd_valid = 1'b0;
    tick();
    total++;
    if (locked !== 1'b0 || fail_cnt !== 2'd0 || pwd_ready !== 1'b1 || debug_active !== 1'b0) begin
      bad++;
      $display("FAIL lock_exit: lck=%0b fc=%0d rdy=%0b dbg=%0b, want 0 0 1 0",
               locked, fail_cnt, pwd_ready, debug_active);
    end
    $display("lockout released after 16 cycles");
  endtask

  task automatic test_fail_then_pass();
    debug_req = 1'b1; usr_mode = 2'd0;
    present(BAD_PWD);
    present(BAD_PWD);
    total++;
    if (fail_cnt !== 2'd2 || locked !== 1'b0) begin
      bad++;
      $display("FAIL two_wrong: fc=%0d lck=%0b, want 2 0", fail_cnt, locked);
    end
    present(REF_PWD);
    total++;
    if (debug_active !== 1'b1 || fail_cnt !== 2'd0 || mode_o !== 2'd3) begin
      bad++;
      $display("FAIL pass_after_fail: dbg=%0b fc=%0d mode=%0d, want 1 0 3",
               debug_active, fail_cnt, mode_o);
    end
    debug_req = 1'b0;
    tick();
    total++;
    if (debug_active !== 1'b0 || mode_o !== 2'd0) begin
      bad++;
      $display("FAIL pass_exit: dbg=%0b mode=%0d, want 0 0", debug_active, mode_o);
    end
    $display("two failures then success -> debug with fail_cnt cleared");
  endtask

  task automatic test_timeout();
    int cycles;
    debug_req = 1'b1; usr_mode = 2'd3;
    present(REF_PWD);
    total++;
    if (debug_active !== 1'b1) begin
      bad++;
      $display("FAIL to_entry: dbg=%0b, want 1", debug_active);
    end
    cycles = 0;
    while (debug_active === 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
    total++;
    if (cycles !== 64) begin
      bad++;
      $display("FAIL to_length: cycles=%0d, want 64", cycles);
    end
    total++;
    if (mode_o !== 2'd1 || pwd_ready !== 1'b1) begin
      bad++;
      $display("FAIL to_exit: mode=%0d rdy=%0b, want 1 1", mode_o, pwd_ready);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if (debug_active !== 1'b0 || mode_o !== 2'd1) begin
        bad++;
        $display("FAIL to_no_reentry[%0d]: dbg=%0b mode=%0d, want 0 1",
                 k, debug_active, mode_o);
      end
    end
    $display("debug timeout after %0d cycles, no re-entry", cycles);
  endtask

  task automatic test_reset_mid();
    debug_req = 1'b1; usr_mode = 2'd3;
    present(REF_PWD);
    tick(); tick();
    rst = 1'b1;
    tick();
    total++;
    if (mode_o !== 2'd0 || debug_active !== 1'b0 || locked !== 1'b0 ||
        fail_cnt !== 2'd0 || pwd_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_debug: mode=%0d dbg=%0b lck=%0b fc=%0d rdy=%0b, want 0 0 0 0 1",
               mode_o, debug_active, locked, fail_cnt, pwd_ready);
    end
    rst = 1'b0;
    present(BAD_PWD);
    present(BAD_PWD);
    present(BAD_PWD);
    tick(); tick(); tick();
    total++;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre_lock: lck=%0b, want 1", locked);
    end
    rst = 1'b1;
    tick();
    total++;
    if (mode_o !== 2'd0 || debug_active !== 1'b0 || locked !== 1'b0 ||
        fail_cnt !== 2'd0 || pwd_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_lock: mode=%0d dbg=%0b lck=%0b fc=%0d rdy=%0b, want 0 0 0 0 1",
               mode_o, debug_active, locked, fail_cnt, pwd_ready);
    end
    // Reset beats a simultaneous valid password.
    pwd_valid = 1'b1; pwd_data = REF_PWD;
    tick();
    pwd_valid = 1'b0;
    rst = 1'b0;
    tick(); tick();
    total++;
    if (debug_active !== 1'b0 || pwd_ready !== 1'b1 || mode_o !== 2'd1) begin
      bad++;
      $display("FAIL rst_priority: dbg=%0b rdy=%0b mode=%0d, want 0 1 1",
               debug_active, pwd_ready, mode_o);
    end
    $display("reset mid-debug and mid-lockout returns to idle");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_clamp();
    test_ignore_no_debug();
    test_debug_entry();
    test_lockout();
    test_fail_then_pass();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
